// File: rtl/uop_ecdsa_pkg.sv
// uop_ecdsa_pkg: microcode word layout, opcode/exec encodings and FSM states
// shared by the sequencer, its decoder and the microprogram ROMs.
package uop_ecdsa_pkg;
    localparam int ADDR_W_DEF = 6;
    localparam int UOP_W_DEF = 20;
    localparam int FIELD_W = 4;
    localparam int OPC_LSB = 16;
    localparam int SRCA_LSB = 12;
    localparam int SRCB_LSB = 8;
    localparam int DST_LSB = 4;
    localparam int EXEC_LSB = 0;
    typedef enum logic [3:0] {
        OP_RDY = 4'h0,
        OP_CMP = 4'h1,
        OP_MOV = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_MUL = 4'h5
    } opcode_e;
    typedef enum logic [3:0] {
        EX_ALWAYS = 4'h0,
        EX_IF_NZ  = 4'h1,
        EX_IF_Z   = 4'h2
    } exec_e;
    localparam logic [3:0] REG_X  = 4'h0;
    localparam logic [3:0] REG_Y  = 4'h1;
    localparam logic [3:0] REG_Z  = 4'h2;
    localparam logic [3:0] REG_T0 = 4'h3;
    localparam logic [3:0] REG_T1 = 4'h4;
    localparam logic [3:0] REG_T2 = 4'h5;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_NEXT, S_DONE
    } state_e;
    function automatic logic [UOP_W_DEF-1:0] make_uop(input logic [3:0] op, input logic [3:0] a,
                                                      input logic [3:0] b, input logic [3:0] d,
                                                      input logic [3:0] ex);
        return {op, a, b, d, ex};
    endfunction
endpackage

// File: rtl/uop_sequencer_if.sv
// uop_sequencer_if: start/done handshake, ROM fetch port and ALU issue port
// of the micro-op sequencer.
interface uop_sequencer_if
    import uop_ecdsa_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int UOP_W = UOP_W_DEF
);
    logic              ena;
    logic              rdy;
    logic [ADDR_W-1:0] uop_addr;
    logic [UOP_W-1:0]  uop_data;
    logic              alu_ena;
    logic [3:0]        alu_opcode;
    logic [3:0]        alu_src_a;
    logic [3:0]        alu_src_b;
    logic [3:0]        alu_dst;
    logic              alu_rdy;
    logic              alu_cmp_zero;
    modport master (
        input  ena, uop_data, alu_rdy, alu_cmp_zero,
        output rdy, uop_addr, alu_ena, alu_opcode, alu_src_a, alu_src_b, alu_dst
    );
    modport slave (
        output ena, uop_data, alu_rdy, alu_cmp_zero,
        input  rdy, uop_addr, alu_ena, alu_opcode, alu_src_a, alu_src_b, alu_dst
    );
endinterface

// File: rtl/uop_decoder.sv
// uop_decoder: splits a microcode word into fields and evaluates its
// execution condition against the CMP flag.
module uop_decoder
    import uop_ecdsa_pkg::*;
#(
    parameter int UOP_W = UOP_W_DEF
) (
    input  logic [UOP_W-1:0] uop_i,
    input  logic             flag_z_i,
    output logic [3:0]       opcode_o,
    output logic [3:0]       src_a_o,
    output logic [3:0]       src_b_o,
    output logic [3:0]       dst_o,
    output logic             exec_ok_o,
    output logic             is_rdy_o,
    output logic             is_cmp_o
);
    logic [3:0] exec;
    always_comb begin
        opcode_o = uop_i[OPC_LSB +: FIELD_W];
        src_a_o = uop_i[SRCA_LSB +: FIELD_W];
        src_b_o = uop_i[SRCB_LSB +: FIELD_W];
        dst_o = uop_i[DST_LSB +: FIELD_W];
        exec = uop_i[EXEC_LSB +: FIELD_W];
        // reserved exec codes never execute
        exec_ok_o = exec == EX_ALWAYS ? 1'b1 :
                    exec == EX_IF_NZ  ? !flag_z_i :
                    exec == EX_IF_Z   ? flag_z_i : 1'b0;
        is_rdy_o = opcode_o == OP_RDY;
        is_cmp_o = opcode_o == OP_CMP;
    end
endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: fetches microcode from a registered ROM and issues one
// micro-op at a time to the modular-arithmetic unit until RDY or address wrap.
module uop_sequencer
    import uop_ecdsa_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int UOP_W = UOP_W_DEF
) (
    input logic            clk,
    input logic            rst,
    uop_sequencer_if.master bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flag_q, flag_d;
    logic              rdy_q, rdy_d;
    logic              alu_ena_q, alu_ena_d;
    logic [3:0]        op_q, op_d, a_q, a_d, b_q, b_d, dst_q, dst_d;
    logic [3:0]        dec_op, dec_a, dec_b, dec_dst;
    logic              dec_ok, dec_rdy, dec_cmp;

    uop_decoder #(.UOP_W(UOP_W)) u_dec (
        .uop_i(bus.uop_data), .flag_z_i(flag_q),
        .opcode_o(dec_op), .src_a_o(dec_a), .src_b_o(dec_b), .dst_o(dec_dst),
        .exec_ok_o(dec_ok), .is_rdy_o(dec_rdy), .is_cmp_o(dec_cmp)
    );

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        flag_d = flag_q;
        rdy_d = rdy_q;
        alu_ena_d = 1'b0;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        dst_d = dst_q;
        case (state_q)
            S_IDLE: if (bus.ena) begin
                addr_d = '0;
                flag_d = 1'b0;
                rdy_d = 1'b0;
                state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                state_d = dec_rdy ? S_DONE : dec_ok ? S_WAIT : S_NEXT;
                if (!dec_rdy && dec_ok) begin
                    op_d = dec_op;
                    a_d = dec_a;
                    b_d = dec_b;
                    dst_d = dec_dst;
                    alu_ena_d = 1'b1;
                end
            end
            // alu_rdy during the issue cycle itself is too early to be genuine
            S_WAIT: if (bus.alu_rdy && !alu_ena_q) begin
                flag_d = op_q == OP_CMP ? bus.alu_cmp_zero : flag_q;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = &addr_q ? S_DONE : S_FETCH;
                addr_d = &addr_q ? addr_q : addr_q + 1'b1;
            end
            S_DONE: begin
                rdy_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q <= '0;
            flag_q <= 1'b0;
            rdy_q <= 1'b1;
            alu_ena_q <= 1'b0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            dst_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            flag_q <= flag_d;
            rdy_q <= rdy_d;
            alu_ena_q <= alu_ena_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            dst_q <= dst_d;
        end
    end

    assign bus.rdy = rdy_q;
    assign bus.uop_addr = addr_q;
    assign bus.alu_ena = alu_ena_q;
    assign bus.alu_opcode = op_q;
    assign bus.alu_src_a = a_q;
    assign bus.alu_src_b = b_q;
    assign bus.alu_dst = dst_q;
endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Fetch/decode/issue engine that consumes 20-bit microcode words from a registered microprogram ROM (e.g. the point-doubling ROM) and drives the shared modular-arithmetic datapath one micro-op at a time.
- Sits between the curve point-operation controller (start/done) and the ROM plus operand bank/arithmetic unit.
- Handles the conditional-execution flag captured by CMP and terminates on the RDY opcode.

Parameters:
- ADDR_W, 6, microprogram address width (64 words)
- UOP_W, 20, microcode word width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ena  in  1  start pulse; sampled only in IDLE
- rdy  out  1  high when idle/finished; low while a program runs
- uop_addr  out  ADDR_W  ROM address; registered
- uop_data  in  UOP_W  ROM word; valid one clock after uop_addr changes
- alu_ena  out  1  one-cycle issue strobe to arithmetic unit
- alu_opcode  out  4  opcode field of issued uop
- alu_src_a  out  4  operand-A select
- alu_src_b  out  4  operand-B select
- alu_dst  out  4  destination select
- alu_rdy  in  1  arithmetic unit done; may be high in the cycle after alu_ena at earliest
- alu_cmp_zero  in  1  CMP result (operands equal), valid when alu_rdy rises after a CMP

Behaviour:
- Word format (MSB first): opcode[19:16], src_a[15:12], src_b[11:8], dst[7:4], exec[3:0].
- Reset: rdy=1, uop_addr=0, alu_ena=0, alu_opcode/src/dst=0, flag_z=0, state=IDLE. Reset mid-program aborts immediately; no pending alu_ena is issued afterwards.
- States:
  - IDLE: rdy=1. On ena: uop_addr<=0, flag_z<=0, rdy<=0, go to FETCH.
  - FETCH: one cycle; the ROM latches uop_addr.
  - DECODE: uop_data is valid.
    - opcode==RDY: go to DONE.
    - Exec condition false: skip; go to NEXT.
    - Otherwise: register the fields onto alu_* outputs, pulse alu_ena for exactly one cycle, go to WAIT.
  - WAIT: hold alu_opcode/src/dst stable. On alu_rdy: if opcode==CMP, flag_z<=alu_cmp_zero. Go to NEXT.
  - NEXT: if uop_addr==2^ADDR_W-1, go to DONE (wrap is end-of-program, never address 0); else uop_addr<=uop_addr+1, go to FETCH.
  - DONE: rdy<=1, go to IDLE. uop_addr holds its last value.
- Exec codes:
  - ALWAYS=0: execute unconditionally.
  - IF_NZ=1: execute only if flag_z==0.
  - IF_Z=2: execute only if flag_z==1.
  - Other codes are reserved and treated as skip.
- Latency:
  - Skipped uop: 3 cycles (FETCH, DECODE, NEXT).
  - Executed uop: 3 cycles + ALU cycles from alu_ena to alu_rdy inclusive.
  - RDY at address k: rdy rises 3k + Σ(ALU cycles) + 3 cycles after ena is sampled.
- Boundary cases:
  - ena while running is ignored.
  - alu_rdy outside WAIT is ignored.
  - alu_rdy high in the cycle after alu_ena is accepted.
  - ena and rst simultaneously: reset wins.
  - flag_z persists across uops until the next CMP or program start.

Decomposition:
- Shared package/include `uop_ecdsa_pkg`: opcode codes (RDY, CMP, MOV, ADD, SUB, MUL), exec codes, field bit positions/widths, src/dst encodings. The same package is used by the ROMs.
- Optional sub-module `uop_decoder` (combinational): field split, exec-condition evaluation, is_rdy/is_cmp flags.
- The FSM stays in the top module.

Test Plan:
- Program {MOV,ADD,RDY}, alu_rdy 2 cycles after each alu_ena -> exactly two alu_ena pulses carrying the correct fields; rdy rises 3·2+2·2+3=13 cycles after ena; uop_addr stops at 2.
- CMP with alu_cmp_zero=1, then three IF_NZ uops, then RDY at address 4 -> one alu_ena only (for the CMP); the three uops are skipped in 3 cycles each.
- Same program with alu_cmp_zero=0 -> four alu_ena pulses; flag_z=0 at the end.
- ROM with no RDY word (all ALWAYS MOV) -> 64 issues, then rdy=1 with uop_addr=63; no wrap fetch of address 0.
- rst asserted while in WAIT -> all outputs return to reset values asynchronously; a later ena restarts at address 0.
- ena pulsed again mid-program and alu_rdy pulsed while in FETCH -> both ignored; issue sequence unchanged.
